seq_shift_unit: RTL and testbench

//  Parametrised multi-cycle shifter for the datapath: LSL/LSR/ASR/ROR of a W-bit operand by an
//  8-bit amount, STEP bit positions per clock, with ARM-style carry-out. Start/busy/done

---
 rtl/seq_shift_unit_pkg.sv | 17 +
 rtl/seq_shift_unit_if.sv | 27 ++
 rtl/seq_shift_step.sv | 39 +++
 rtl/seq_shift_unit.sv | 91 +++++++++
 tb/tb_seq_shift_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings for the multi-cycle shifter: operation codes and FSM states.
package seq_shift_unit_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the control FSM (master) and the shifter (slave).
interface seq_shift_unit_if
    import seq_shift_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int AMT_W = 8
);
    logic             start;
    op_e              op;
    logic [W-1:0]     operand;
    logic [AMT_W-1:0] amount;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             carry_out;

    modport master (
        output start, op, operand, amount, carry_in,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op, operand, amount, carry_in,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/seq_shift_step.sv
// One shift step: moves value by k (0..STEP) positions and reports the last bit out.
// k==0 returns value unchanged; the caller must not take carry in that case.
module seq_shift_step
    import seq_shift_unit_pkg::*;
#(
    parameter int W  = 32,
    parameter int KW = 6
) (
    input  logic [W-1:0]  value,
    input  op_e           op,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  shifted,
    output logic          carry
);
    logic [W-1:0] fill;
    logic [W:0]   lwide;
    logic [W:0]   rwide;

    // Left shift carries out of bit W; right shifts use a {fill,value,guard} window
    // so the guard bit catches the last bit shifted out.
    always_comb begin
        fill = '0;
        case (op)
            OP_ASR:  fill = {W{value[W-1]}};
            OP_ROR:  fill = value;
            default: fill = '0;
        endcase
        lwide = {1'b0, value} << k;
        rwide = (W+1)'({fill, value, 1'b0} >> k);
        if (op == OP_LSL) begin
            shifted = lwide[W-1:0];
            carry   = lwide[W];
        end else begin
            shifted = rwide[W:1];
            carry   = rwide[0];
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, up to STEP positions per clock, with
// ARM-style carry-out and a start/busy/done handshake.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    seq_shift_unit_if.slave bus
);
    // rem must hold W+1 (saturated amount), so it needs clog2(W+2) bits.
    localparam int            RW     = $clog2(W + 2);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);
    localparam logic [RW-1:0] SAT    = RW'(W + 1);

    state_e        state_q, state_d;
    op_e           op_q;
    logic [W-1:0]  res_q;
    logic          c_q;
    logic [RW-1:0] rem_q;
    logic [RW-1:0] eff;
    logic [RW-1:0] k;
    logic [31:0]   amt32;
    logic [W-1:0]  step_res;
    logic          step_c;

    // Effective amount: linear shifts saturate at W+1 (any further shifting
    // leaves the same result and carry); rotates fold into 1..W.
    always_comb begin
        amt32 = 32'(bus.amount);
        if (bus.op == OP_ROR)
            eff = (amt32 == 32'd0) ? '0 : RW'(((amt32 - 32'd1) & 32'(W - 1)) + 32'd1);
        else
            eff = (amt32 > 32'(W + 1)) ? SAT : RW'(amt32);
        k = (rem_q < STEP_R) ? rem_q : STEP_R;
    end

    seq_shift_step #(.W(W), .KW(RW)) u_step (
        .value   (res_q),
        .op      (op_q),
        .k       (k),
        .shifted (step_res),
        .carry   (step_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: leave SHIFT in the cycle that consumes the last of rem
    // (or immediately when rem is already zero).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (rem_q == k) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, shift while in SHIFT, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= OP_LSL;
            res_q <= '0;
            c_q   <= 1'b0;
            rem_q <= '0;
        end else if (state_q == ST_IDLE && bus.start) begin
            op_q  <= bus.op;
            res_q <= bus.operand;
            c_q   <= bus.carry_in;
            rem_q <= eff;
        end else if (state_q == ST_SHIFT && k != '0) begin
            res_q <= step_res;
            c_q   <= step_c;
            rem_q <= rem_q - k;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = res_q;
    assign bus.carry_out = c_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed + random bench: four shifters (STEP 1,3,8,32) driven in parallel.
module tb_seq_shift_unit;
    import seq_shift_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    op_e         op_s = OP_LSL;
    logic [31:0] operand = '0;
    logic [7:0]  amount = '0;
    logic        cin = 1'b0;

    logic        done_v [4];
    logic        busy_v [4];
    logic        cout_v [4];
    logic [31:0] res_v  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 8 : 32;
        seq_shift_unit_if #(.W(32), .AMT_W(8)) bus ();
        assign bus.start    = start;
        assign bus.op       = op_s;
        assign bus.operand  = operand;
        assign bus.amount   = amount;
        assign bus.carry_in = cin;
        assign done_v[g]    = bus.done;
        assign busy_v[g]    = bus.busy;
        assign cout_v[g]    = bus.carry_out;
        assign res_v[g]     = bus.result;
        seq_shift_unit #(.W(32), .STEP(ST), .AMT_W(8)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    // Bit-serial reference: true shift/rotate by the full amount.
    function automatic void model(input op_e op, input logic [31:0] v, input int amt,
                                  input logic c_in, output logic [31:0] r, output logic c);
        r = v;
        c = c_in;
        for (int i = 0; i < amt; i++) begin
            case (op)
                OP_LSL: begin c = r[31]; r = {r[30:0], 1'b0}; end
                OP_LSR: begin c = r[0];  r = {1'b0, r[31:1]}; end
                OP_ASR: begin c = r[0];  r = {r[31], r[31:1]}; end
                default: begin c = r[0]; r = {r[0], r[31:1]}; end
            endcase
        end
    endfunction

    function automatic int exp_lat(input op_e op, input int amt, input int step);
        int e;
        int n;
        if (op == OP_ROR) e = (amt == 0) ? 0 : ((amt - 1) % 32) + 1;
        else              e = (amt > 33) ? 33 : amt;
        n = (e + step - 1) / step;
        return 1 + ((n < 1) ? 1 : n);
    endfunction

    // Issue one request, then gather each shifter's result, carry and latency
    // (cycles from the accept cycle to the done cycle; 0 if never seen).
    task automatic run_op(input op_e op, input logic [31:0] v, input int amt, input logic c_in,
                          output logic [3:0][31:0] r, output logic [3:0] c, output int lat [4]);
        logic [3:0] got;
        @(negedge clk);
        op_s = op; operand = v; amount = 8'(amt); cin = c_in; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = '0; r = '0; c = '0;
        for (int i = 0; i < 4; i++) lat[i] = 0;
        for (int n = 1; n <= 300 && got != 4'hF; n++) begin
            for (int i = 0; i < 4; i++)
                if (!got[i] && done_v[i]) begin
                    got[i] = 1'b1; lat[i] = n; r[i] = res_v[i]; c[i] = cout_v[i];
                end
            if (got != 4'hF) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || res_v[i] !== 32'h0 || cout_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b done=%b result=%h carry=%b, want all 0",
                         i, busy_v[i], done_v[i], res_v[i], cout_v[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lsl_basic();
        logic [3:0][31:0] r;
        logic [3:0] c;
        int lat [4];
        int want_lat [4] = '{5, 3, 2, 2};
        run_op(OP_LSL, 32'h0000_0001, 4, 1'b0, r, c, lat);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r[i] !== 32'h0000_0010 || c[i] !== 1'b0 || lat[i] != want_lat[i]) begin
                errors++;
                $display("FAIL lsl_basic[%0d]: got %h C=%b lat=%0d, want 00000010 C=0 lat=%0d",
                         i, r[i], c[i], lat[i], want_lat[i]);
            end
        end
    endtask

    typedef struct {
        op_e         op;
        logic [31:0] v;
        int          amt;
        logic        cin;
        logic [31:0] er;
        logic        ec;
    } vec_t;

    task automatic test_boundaries();
        logic [3:0][31:0] r;
        logic [3:0] c;
        int lat [4];
        vec_t tbl [11] = '{
            '{OP_ASR, 32'h8000_0000,  40, 1'b0, 32'hFFFF_FFFF, 1'b1},
            '{OP_LSR, 32'h8000_0000,  33, 1'b1, 32'h0000_0000, 1'b0},
            '{OP_ROR, 32'h8000_0001,  32, 1'b0, 32'h8000_0001, 1'b1},
            '{OP_ROR, 32'h8000_0001,   1, 1'b0, 32'hC000_0000, 1'b1},
            '{OP_ROR, 32'h8000_0001,   0, 1'b0, 32'h8000_0001, 1'b0},
            '{OP_LSL, 32'h0000_0001,  32, 1'b0, 32'h0000_0000, 1'b1},
            '{OP_LSL, 32'hFFFF_FFFF,  33, 1'b1, 32'h0000_0000, 1'b0},
            '{OP_LSR, 32'h8000_0000,  32, 1'b0, 32'h0000_0000, 1'b1},
            '{OP_ROR, 32'h8000_0001,  64, 1'b0, 32'h8000_0001, 1'b1},
            '{OP_LSL, 32'h1234_5678,   0, 1'b1, 32'h1234_5678, 1'b1},
            '{OP_ASR, 32'h7FFF_FFFF, 255, 1'b1, 32'h0000_0000, 1'b0}
        };
        for (int t = 0; t < 11; t++) begin
            run_op(tbl[t].op, tbl[t].v, tbl[t].amt, tbl[t].cin, r, c, lat);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (r[i] !== tbl[t].er || c[i] !== tbl[t].ec || lat[i] == 0) begin
                    errors++;
                    $display("FAIL boundary%0d[%0d]: got %h C=%b lat=%0d, want %h C=%b",
                             t, i, r[i], c[i], lat[i], tbl[t].er, tbl[t].ec);
                end
            end
        end
    endtask

    task automatic test_step8();
        logic [3:0][31:0] r;
        logic [3:0] c;
        int lat [4];
        int want_lat [4] = '{13, 5, 3, 2};
        run_op(OP_LSL, 32'h1234_5678, 12, 1'b0, r, c, lat);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (r[i] !== 32'h4567_8000 || c[i] !== 1'b1 || lat[i] != want_lat[i]) begin
                errors++;
                $display("FAIL step8[%0d]: got %h C=%b lat=%0d, want 45678000 C=1 lat=%0d",
                         i, r[i], c[i], lat[i], want_lat[i]);
            end
        end
    endtask

    task automatic test_start_held();
        int pulses = 0;
        int n;
        @(negedge clk);
        op_s = OP_LSL; operand = 32'h1234_5678; amount = 8'd12; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (done_v[2]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL held_pulses: got %0d done pulses, want 1", pulses);
        end
        @(negedge clk);
        checks++;
        if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL held_idle: busy=%b done=%b, want 0 0", busy_v[2], done_v[2]);
        end
        @(negedge clk);
        checks++;
        if (busy_v[2] !== 1'b1) begin
            errors++;
            $display("FAIL held_reaccept: busy=%b, want 1", busy_v[2]);
        end
        start = 1'b0;
        n = 0;
        while ((busy_v[0] || busy_v[1] || busy_v[2] || busy_v[3]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL held_drain: still busy after %0d cycles, want idle", n);
        end
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        @(negedge clk);
        op_s = OP_LSR; operand = 32'hFFFF_0000; amount = 8'd20; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: busy=%b, want 1", busy_v[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || res_v[i] !== 32'h0 || cout_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL abort_state[%0d]: busy=%b done=%b result=%h C=%b, want 0 0 0 0",
                         i, busy_v[i], done_v[i], res_v[i], cout_v[i]);
            end
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (done_v[i]) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", pulses);
        end
    endtask

    task automatic test_random();
        logic [3:0][31:0] r;
        logic [3:0] c;
        int lat [4];
        int steps [4] = '{1, 3, 8, 32};
        op_e op;
        logic [31:0] v;
        int amt;
        logic ci;
        logic [31:0] er;
        logic ec;
        int el;
        for (int t = 0; t < 30; t++) begin
            op  = op_e'(2'($urandom_range(0, 3)));
            v   = $urandom;
            amt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 70));
            ci  = 1'($urandom_range(0, 1));
            model(op, v, amt, ci, er, ec);
            run_op(op, v, amt, ci, r, c, lat);
            for (int i = 0; i < 4; i++) begin
                el = exp_lat(op, amt, steps[i]);
                checks++;
                if (r[i] !== er || c[i] !== ec || lat[i] != el) begin
                    errors++;
                    $display("FAIL random%0d[%0d] op=%0d v=%h amt=%0d: got %h C=%b lat=%0d, want %h C=%b lat=%0d",
                             t, i, op, v, amt, r[i], c[i], lat[i], er, ec, el);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsl_basic();
        test_boundaries();
        test_step8();
        test_start_held();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
